gemm_result_reader: RTL and testbench

Readback engine for the output-C SRAM written by the GeMM accelerator. After a GeMM completes, it walks C in block row-major order (address = m*N_size + n, i.e. linear 0..M*N-1). Each block is read from SRAM and unpacked into its meshRow*meshCol OutDataWidth-bit results. These are emitted one per beat on a valid/ready stream toward the host or DMA side, so the block sits between the C SRAM read port and the host interface.

---
 rtl/gemm_result_reader.sv | 120 ++++++++++++
 tb/tb_gemm_result_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_reader.sv
// Readback engine for the GeMM output-C SRAM: walks blocks 0..M*N-1, reads each
// block once and streams its meshRow*meshCol results out one per valid/ready beat.
module gemm_result_reader #(
   parameter int OutDataWidth  = 32,
   parameter int AddrWidth     = 16,
   parameter int SizeAddrWidth = 8,
   parameter int meshRow       = 2,
   parameter int meshCol       = 2
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    start_i,
   input  logic [SizeAddrWidth-1:0]                M_size_i,
   input  logic [SizeAddrWidth-1:0]                N_size_i,
   output logic [AddrWidth-1:0]                    sram_c_addr_o,
   output logic                                    sram_c_re_o,
   input  logic [meshRow*meshCol*OutDataWidth-1:0] sram_c_rdata_i,
   output logic [OutDataWidth-1:0]                 m_data_o,
   output logic                                    m_valid_o,
   input  logic                                    m_ready_i,
   output logic                                    m_last_o,
   output logic                                    busy_o,
   output logic                                    done_o
);

   localparam int P  = meshRow * meshCol;
   localparam int EW = (P > 1) ? $clog2(P) : 1;
   localparam int TW = 2 * SizeAddrWidth;
   localparam logic [EW-1:0] LAST_ELEM = EW'(P - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAPTURE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t                       state_reg, state_next;
   logic [TW-1:0]                blk_reg, blk_next;
   logic [TW-1:0]                total_reg, total_next;
   logic [EW-1:0]                elem_reg, elem_next;
   logic [P*OutDataWidth-1:0]    block_reg, block_next;
   logic [OutDataWidth-1:0]      elem_words [P];
   logic                         final_blk;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg <= S_IDLE;
         blk_reg   <= '0;
         total_reg <= '0;
         elem_reg  <= '0;
         block_reg <= '0;
      end else begin
         state_reg <= state_next;
         blk_reg   <= blk_next;
         total_reg <= total_next;
         elem_reg  <= elem_next;
         block_reg <= block_next;
      end
   end

   assign final_blk = (blk_reg == total_reg - TW'(1));

   always_comb begin
      state_next = state_reg;
      blk_next   = blk_reg;
      total_next = total_reg;
      elem_next  = elem_reg;
      block_next = block_reg;
      case (state_reg)
         S_IDLE: begin
            if (start_i) begin
               total_next = TW'(M_size_i) * TW'(N_size_i);
               blk_next   = '0;
               elem_next  = '0;
               state_next = ((M_size_i != '0) && (N_size_i != '0)) ? S_READ : S_DONE;
            end
         end
         S_READ: state_next = S_CAPTURE;
         S_CAPTURE: begin
            block_next = sram_c_rdata_i;
            elem_next  = '0;
            state_next = S_STREAM;
         end
         S_STREAM: begin
            if (m_ready_i) begin
               if (elem_reg == LAST_ELEM) begin
                  elem_next = '0;
                  if (final_blk) begin
                     state_next = S_DONE;
                  end else begin
                     blk_next   = blk_reg + TW'(1);
                     state_next = S_READ;
                  end
               end else begin
                  elem_next = elem_reg + EW'(1);
               end
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Element 0 sits in the LSBs of the SRAM word.
   for (genvar gi = 0; gi < P; gi++) begin : g_unpack
      assign elem_words[gi] = block_reg[gi*OutDataWidth +: OutDataWidth];
   end

   assign sram_c_addr_o = AddrWidth'(blk_reg);
   assign sram_c_re_o   = (state_reg == S_READ);
   assign m_valid_o     = (state_reg == S_STREAM);
   assign m_data_o      = m_valid_o ? elem_words[elem_reg] : '0;
   assign m_last_o      = m_valid_o && (elem_reg == LAST_ELEM) && final_blk;
   assign busy_o        = (state_reg == S_READ) || (state_reg == S_CAPTURE) ||
                          (state_reg == S_STREAM);
   assign done_o        = (state_reg == S_DONE);

endmodule

// File: tb/tb_gemm_result_reader.sv
// Scoreboard bench for gemm_result_reader: expected beats and read addresses are
// queued when a job is started and checked as the DUT produces them.
module tb_gemm_result_reader;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int SW = 8;
   localparam int P  = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            start_i;
   logic [SW-1:0]   M_size_i;
   logic [SW-1:0]   N_size_i;
   logic [AW-1:0]   sram_c_addr_o;
   logic            sram_c_re_o;
   logic [P*DW-1:0] sram_c_rdata_i = '0;
   logic [DW-1:0]   m_data_o;
   logic            m_valid_o;
   logic            m_ready_i;
   logic            m_last_o;
   logic            busy_o;
   logic            done_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int re_cnt = 0;
   int beat_cnt = 0;
   int done_cyc = -1;
   int re_cyc = -1;
   int first_valid_cyc = -1;
   int last_beat_cyc = -1;
   int tstart = 0;
   int pat_idx = 0;
   bit stall_mode = 0;
   bit pat [4];
   bit prev_stall = 0;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   exp_t    exp_q [$];
   int      addr_q [$];

   gemm_result_reader #(
      .OutDataWidth (DW),
      .AddrWidth    (AW),
      .SizeAddrWidth(SW),
      .meshRow      (2),
      .meshCol      (2)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .M_size_i      (M_size_i),
      .N_size_i      (N_size_i),
      .sram_c_addr_o (sram_c_addr_o),
      .sram_c_re_o   (sram_c_re_o),
      .sram_c_rdata_i(sram_c_rdata_i),
      .m_data_o      (m_data_o),
      .m_valid_o     (m_valid_o),
      .m_ready_i     (m_ready_i),
      .m_last_o      (m_last_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc++;

   function automatic logic [P*DW-1:0] blk_word(input logic [AW-1:0] a);
      logic [P*DW-1:0] w;
      w = '0;
      for (int e = 0; e < P; e++) w[e*DW +: DW] = 32'(a) * 4 + 32'(e);
      return w;
   endfunction

   // SRAM model with one-cycle read latency
   always @(posedge clk_i) begin
      if (sram_c_re_o) sram_c_rdata_i <= blk_word(sram_c_addr_o);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_hold", 64'(m_valid_o), 64'(1));
            chk("stall_data_hold", 64'(m_data_o), 64'(prev_data));
            chk("stall_last_hold", 64'(m_last_o), 64'(prev_last));
         end
         if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_valid_o && m_ready_i) begin
            exp_t e;
            beat_cnt++;
            $display("beat %0d @cyc %0d: data=%0d last=%0b", beat_cnt, cyc, m_data_o, m_last_o);
            chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("beat_data", 64'(m_data_o), 64'(e.data));
               chk("beat_last", 64'(m_last_o), 64'(e.last));
            end
            if (m_last_o) last_beat_cyc = cyc;
         end
         if (m_last_o) chk("last_only_valid", 64'(m_valid_o), 64'(1));
         if (sram_c_re_o) begin
            re_cnt++;
            re_cyc = cyc;
            chk("read_expected", 64'(addr_q.size() != 0), 64'(1));
            if (addr_q.size() != 0) chk("read_addr", 64'(sram_c_addr_o), 64'(addr_q.pop_front()));
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            $display("done @cyc %0d", cyc);
            chk("busy_on_done", 64'(busy_o), 64'(0));
         end
         prev_stall = m_valid_o && !m_ready_i;
         prev_data  = m_data_o;
         prev_last  = m_last_o;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
      if (stall_mode) begin
         m_ready_i = pat[pat_idx % 4];
         pat_idx++;
      end else begin
         m_ready_i = 1'b1;
      end
   endtask

   task automatic push_job(input int m, input int n);
      for (int k = 0; k < m * n; k++) begin
         addr_q.push_back(k);
         for (int e = 0; e < P; e++) begin
            exp_t x;
            x.data = 32'(4 * k + e);
            x.last = (k == m * n - 1) && (e == P - 1);
            exp_q.push_back(x);
         end
      end
   endtask

   task automatic pulse_start(input int m, input int n);
      M_size_i = SW'(m);
      N_size_i = SW'(n);
      start_i  = 1'b1;
      tstart   = cyc;
      step();
      start_i  = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int i;
      i = 0;
      while (done_cnt < target && i < budget) begin
         step();
         i++;
      end
      chk(tag, 64'(done_cnt >= target), 64'(1));
   endtask

   initial begin
      int base_done;
      int base_beats;
      int base_re;
      int i;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      rst_ni = 1'b0;
      start_i = 1'b0;
      M_size_i = '0;
      N_size_i = '0;
      m_ready_i = 1'b0;
      repeat (3) step();
      @(negedge clk_i);
      chk("reset_outputs", 64'({sram_c_addr_o, sram_c_re_o, m_data_o, m_valid_o,
                                m_last_o, busy_o, done_o}), 64'(0));
      step();
      rst_ni = 1'b1;
      step();

      // 2x3 job, ready always high
      base_done = done_cnt;
      base_beats = beat_cnt;
      push_job(2, 3);
      pulse_start(2, 3);
      wait_done(base_done + 1, 200, "t1_done_reached");
      chk("t1_beats", 64'(beat_cnt - base_beats), 64'(24));
      chk("t1_reads", 64'(re_cnt), 64'(6));
      chk("t1_done_after_last", 64'(done_cyc), 64'(last_beat_cyc + 1));
      chk("t1_exp_empty", 64'(exp_q.size()), 64'(0));
      step();

      // same job with ready pattern 1,0,0,1
      stall_mode = 1;
      pat_idx = 0;
      base_done = done_cnt;
      base_beats = beat_cnt;
      push_job(2, 3);
      pulse_start(2, 3);
      wait_done(base_done + 1, 400, "t2_done_reached");
      chk("t2_beats", 64'(beat_cnt - base_beats), 64'(24));
      chk("t2_exp_empty", 64'(exp_q.size()), 64'(0));
      stall_mode = 0;
      step();

      // zero-size job
      base_done = done_cnt;
      base_re = re_cnt;
      base_beats = beat_cnt;
      @(negedge clk_i);
      chk("t3_busy_before", 64'(busy_o), 64'(0));
      step();
      pulse_start(0, 5);
      @(negedge clk_i);
      chk("t3_done_t1", 64'(done_o), 64'(1));
      chk("t3_done_cyc", 64'(cyc), 64'(tstart + 1));
      chk("t3_no_re", 64'(sram_c_re_o), 64'(0));
      chk("t3_no_valid", 64'(m_valid_o), 64'(0));
      chk("t3_busy", 64'(busy_o), 64'(0));
      repeat (5) step();
      chk("t3_one_done", 64'(done_cnt - base_done), 64'(1));
      chk("t3_no_reads", 64'(re_cnt - base_re), 64'(0));
      chk("t3_no_beats", 64'(beat_cnt - base_beats), 64'(0));

      // start pulse mid-stream is ignored
      base_done = done_cnt;
      base_beats = beat_cnt;
      push_job(2, 2);
      pulse_start(2, 2);
      repeat (8) step();
      chk("t4_busy_mid", 64'(busy_o), 64'(1));
      pulse_start(1, 1);
      wait_done(base_done + 1, 200, "t4_done_reached");
      repeat (20) step();
      chk("t4_one_done", 64'(done_cnt - base_done), 64'(1));
      chk("t4_beats", 64'(beat_cnt - base_beats), 64'(16));
      chk("t4_exp_empty", 64'(exp_q.size()), 64'(0));

      // reset after beat 6 of a 2x3 job
      base_beats = beat_cnt;
      push_job(2, 3);
      pulse_start(2, 3);
      i = 0;
      while (beat_cnt < base_beats + 6 && i < 100) begin
         step();
         i++;
      end
      chk("t5_reached_beat6", 64'(beat_cnt - base_beats), 64'(6));
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      exp_q.delete();
      addr_q.delete();
      @(negedge clk_i);
      chk("t5_reset_outputs", 64'({sram_c_addr_o, sram_c_re_o, m_data_o, m_valid_o,
                                   m_last_o, busy_o, done_o}), 64'(0));
      step();
      base_done = done_cnt;
      base_beats = beat_cnt;
      push_job(1, 1);
      pulse_start(1, 1);
      wait_done(base_done + 1, 100, "t5_done_reached");
      chk("t5_beats", 64'(beat_cnt - base_beats), 64'(4));
      chk("t5_exp_empty", 64'(exp_q.size()), 64'(0));
      step();

      // 1x1 latency
      base_done = done_cnt;
      first_valid_cyc = -1;
      push_job(1, 1);
      pulse_start(1, 1);
      wait_done(base_done + 1, 100, "t6_done_reached");
      chk("t6_re_cyc", 64'(re_cyc), 64'(tstart + 1));
      chk("t6_valid_cyc", 64'(first_valid_cyc), 64'(tstart + 3));
      chk("t6_done_cyc", 64'(done_cyc), 64'(tstart + 7));
      repeat (3) step();
      chk("end_exp_empty", 64'(exp_q.size()), 64'(0));
      chk("end_addr_empty", 64'(addr_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
